// File: rtl/uart_pkg.sv
// uart_pkg: UART frame defaults and transmitter state encoding, shared with the receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_STOP_BITS  = 1;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_PARITY_ODD = 0;
endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: UART serialiser with a one-entry holding buffer, paced by an external baud clock
//   clk       system clock, all state on its rising edge
//   rst_n     asynchronous active-low reset
//   baud_clk  baud clock, sampled as data; its rising edge marks a bit boundary
//   tx_data   byte to send, LSB first, low DATA_BITS used
//   tx_valid  upstream offers tx_data
//   tx_ready  holding buffer empty; accept on tx_valid && tx_ready
//   tx_serial registered serial line, idle high
//   tx_busy   frame in progress or byte buffered
//   tx_done   one-cycle pulse at the end of each frame's last stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_EN  = DEF_PARITY_EN,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);
  tx_state_t state, state_d;
  logic       baud_q, tick, load, last_stop;
  logic       buf_full, buf_full_d;
  logic [7:0] buf_data, buf_data_d, shreg, shreg_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic       stop_cnt, stop_cnt_d;
  logic       par, par_d, serial_d;

  assign tick      = baud_clk & ~baud_q;
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
  // ready depends only on the registered buffer flag, so a drain and a refill never share a cycle
  assign tx_ready  = ~buf_full;
  assign tx_busy   = (state != IDLE) | buf_full;

  always_comb begin
    state_d    = state;
    buf_full_d = buf_full;
    buf_data_d = buf_data;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_d      = par;
    load       = 1'b0;
    if (tx_valid && !buf_full) begin
      buf_full_d = 1'b1;
      buf_data_d = tx_data;
    end
    if (tick) begin
      case (state)
        IDLE:   load = buf_full;
        START:  state_d = DATA;
        DATA: begin
          shreg_d   = shreg >> 1;
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP: begin
          if (last_stop) begin
            state_d = IDLE;
            load    = buf_full;
          end else begin
            stop_cnt_d = stop_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // loading from STOP chains the next start bit straight after the last stop bit
    if (load) begin
      state_d    = START;
      buf_full_d = 1'b0;
      shreg_d    = buf_data;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      par_d      = (^buf_data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
    end
    serial_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? shreg_d[0] :
               (state_d == PARITY) ? par_d : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_q    <= 1'b0;
      buf_full  <= 1'b0;
      buf_data  <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par       <= 1'b0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      baud_q    <= baud_clk;
      buf_full  <= buf_full_d;
      buf_data  <= buf_data_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_cnt_d;
      stop_cnt  <= stop_cnt_d;
      par       <= par_d;
      tx_serial <= serial_d;
      tx_done   <= tick && state == STOP && last_stop;
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: checks four transmitter configurations against a frame-level line model
module tb_uart_transmitter;
  localparam bit PE[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit PO[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int SB[4] = '{1, 1, 1, 2};

  logic       clk, rst_n, baud;
  logic [7:0] data[4];
  logic       valid[4], ready[4], ser[4], busy[4], done[4];

  int total = 0, bad = 0, sel = 0, cyc = 0;
  bit rec = 0;
  logic ser_q[$], done_q[$];
  logic [7:0] exp_q[$];

  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud = 0;
    forever begin
      repeat (4) @(posedge clk);
      #1 baud = ~baud;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rec) begin
    ser_q.push_back(ser[sel]);
    done_q.push_back(done[sel]);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // line level of frame position p: start, data LSB first, optional parity, stop bits
  function automatic logic expbit(int i, logic [7:0] b, int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (p == 9 && PE[i]) return (^b) ^ PO[i];
    return 1'b1;
  endfunction

  task automatic start_rec(int i);
    sel = i;
    ser_q.delete();
    done_q.delete();
    exp_q.delete();
    rec = 1;
  endtask

  task automatic send(int i, logic [7:0] b);
    @(negedge clk);
    data[i] = b;
    valid[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      if (ready[i]) begin
        @(posedge clk);
        #1 valid[i] = 0;
        exp_q.push_back(b);
        return;
      end
      @(negedge clk);
    end
    valid[i] = 0;
    total++; bad++;
    $display("FAIL send_timeout dut%0d byte %h: got no accept want accept", i, b);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (!busy[sel]) break;
    end
    repeat (20) @(negedge clk);
    rec = 0;
  endtask

  task automatic check_trace(string name, bit contig);
    int idx = 0, dones = 0, gap, nb;
    logic mism, extra;
    nb = 9 + int'(PE[sel]) + SB[sel];
    foreach (done_q[j]) if (done_q[j] === 1'b1) dones++;
    foreach (exp_q[k]) begin
      gap = 0;
      while (idx < ser_q.size() && ser_q[idx] === 1'b1) begin idx++; gap++; end
      if (contig && k > 0) begin
        total++;
        if (gap != 0) begin bad++; $display("FAIL %s_gap frame %0d: got %0d idle cycles want 0", name, k, gap); end
      end
      mism = 0;
      for (int p = 0; p < nb; p++)
        for (int c = 0; c < 8; c++) begin
          if (idx >= ser_q.size() || ser_q[idx] !== expbit(sel, exp_q[k], p)) mism = 1;
          idx++;
        end
      total++;
      if (mism) begin bad++; $display("FAIL %s_frame %0d byte %h: got line mismatch want %0d bits of 8 cycles", name, k, exp_q[k], nb); end
      total++;
      if (idx >= done_q.size() || done_q[idx] !== 1'b1) begin bad++; $display("FAIL %s_done_pos frame %0d: got no pulse want pulse after last stop", name, k); end
    end
    extra = 0;
    for (int j = idx; j < ser_q.size(); j++) if (ser_q[j] !== 1'b1) extra = 1;
    total++;
    if (extra) begin bad++; $display("FAIL %s_tail: got activity after last frame want idle high", name); end
    total++;
    if (dones != exp_q.size()) begin bad++; $display("FAIL %s_done_count: got %0d want %0d", name, dones, exp_q.size()); end
  endtask

  task automatic check_idle_state(string name);
    for (int i = 0; i < 4; i++) begin
      total++; if (ser[i] !== 1'b1)   begin bad++; $display("FAIL %s_serial dut%0d: got %b want 1", name, i, ser[i]); end
      total++; if (ready[i] !== 1'b1) begin bad++; $display("FAIL %s_ready dut%0d: got %b want 1", name, i, ready[i]); end
      total++; if (busy[i] !== 1'b0)  begin bad++; $display("FAIL %s_busy dut%0d: got %b want 0", name, i, busy[i]); end
      total++; if (done[i] !== 1'b0)  begin bad++; $display("FAIL %s_done dut%0d: got %b want 0", name, i, done[i]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check_idle_state("reset");
    rst_n = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    start_rec(0);
    send(0, 8'hA5);
    wait_idle();
    check_trace("single_a5", 0);
    total++;
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy[0]); end
  endtask

  task automatic test_back_to_back();
    start_rec(0);
    send(0, 8'h00);
    repeat (40) @(negedge clk);
    send(0, 8'hFF);
    wait_idle();
    check_trace("b2b", 1);
  endtask

  task automatic test_parity();
    for (int i = 1; i <= 2; i++) begin
      start_rec(i);
      send(i, 8'h07);
      wait_idle();
      check_trace(i == 1 ? "parity_even" : "parity_odd", 0);
    end
  endtask

  task automatic test_stream();
    logic [7:0] b[3] = '{8'h11, 8'h22, 8'h33};
    start_rec(0);
    for (int k = 0; k < 3; k++) begin
      send(0, b[k]);
      total++;
      if (ready[0] !== 1'b0) begin bad++; $display("FAIL stream_ready_full byte %h: got %b want 0", b[k], ready[0]); end
      total++;
      if (busy[0] !== 1'b1) begin bad++; $display("FAIL stream_busy byte %h: got %b want 1", b[k], busy[0]); end
    end
    wait_idle();
    check_trace("stream", 1);
  endtask

  task automatic test_stop2();
    start_rec(3);
    send(3, 8'h55);
    wait_idle();
    check_trace("stop2", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      start_rec(i);
      for (int n = 0; n < 4; n++) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        send(i, 8'($urandom));
      end
      wait_idle();
      check_trace("random", 0);
    end
  endtask

  task automatic test_reset_mid();
    int s = -1;
    send(0, 8'h3C);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ser[0] === 1'b0) begin s = cyc; break; end
    end
    total++;
    if (s < 0) begin bad++; $display("FAIL rstmid_start: got no start bit want start bit"); end
    send(0, 8'h99);
    total++;
    if (ready[0] !== 1'b0) begin bad++; $display("FAIL rstmid_buffered: got ready %b want 0", ready[0]); end
    while (cyc < s + 36) @(negedge clk);
    rst_n = 0;
    #1;
    check_idle_state("rstmid");
    repeat (3) @(negedge clk);
    start_rec(0);
    rst_n = 1;
    repeat (200) @(negedge clk);
    rec = 0;
    check_trace("rstmid_after", 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      data[i] = 0;
      valid[i] = 0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_stream();
    test_stop2();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 Clock_In  input  1  single system clock; all logic on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Baud_Clk  input  1  baud clock from the baud-rate generator, synchronous to Clock_In; sampled as data, never used as a clock.
REQ-008 Tx_Data  input  8  byte to send; bits [DATA_BITS-1:0] used; LSB sent first.
REQ-009 Tx_Valid  input  1  upstream offers Tx_Data this cycle.
REQ-010 Tx_Ready  output  1  holding buffer empty; a byte is accepted in any cycle where Tx_Valid && Tx_Ready.
REQ-011 Tx_Serial  output  1  registered serial line, idle high.
REQ-012 Tx_Busy  output  1  high while a frame is in progress or the holding buffer is full.
REQ-013 Tx_Done  output  1  one-Clock_In-cycle pulse at the end of the last stop bit of each frame.

Function
REQ-014 Baud tick SHALL be a one-cycle strobe asserted when the registered previous Baud_Clk is 0 and the current Baud_Clk is 1; one bit period = one tick interval.
REQ-015 Accepted bytes SHALL be captured in a one-entry holding buffer; Tx_Ready SHALL be a registered function of buffer state only, so a buffer drained in cycle N allows a new accept no earlier than cycle N+1.
REQ-016 State machine SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: Tx_Serial=1; on a tick with the buffer full, move the buffer into the shift register, empty the buffer, enter START.
REQ-018 START: Tx_Serial=0 for one bit period; on the next tick enter DATA with bit counter 0.
REQ-019 DATA: Tx_Serial = shift register bit 0; on each tick shift right and increment the counter; after DATA_BITS ticks enter PARITY if PARITY_EN, else STOP.
REQ-020 PARITY: Tx_Serial = XOR of the data bits, inverted when PARITY_ODD; one bit period, then STOP.
REQ-021 STOP: Tx_Serial=1 for STOP_BITS bit periods; on the final tick pulse Tx_Done, then enter START directly (loading the buffer) if the buffer is full, else IDLE.
REQ-022 Back-to-back frames SHALL have no idle bit between the stop bit(s) and the next start bit.
REQ-023 Tx_Valid with Tx_Ready low SHALL be ignored with no data loss; upstream must hold Tx_Valid until accepted.
REQ-024 Tx_Serial changes SHALL occur only in the cycle after a tick (registered output), except at reset.
REQ-025 An accept in the same cycle as a buffer load is impossible by REQ-015; the buffer SHALL never be overwritten.

Reset
REQ-026 Reset low SHALL immediately force Tx_Serial=1, Tx_Ready=1, Tx_Busy=0, Tx_Done=0, state IDLE, counters 0, buffer empty, previous-Baud_Clk register 0.
REQ-027 Reset mid-frame SHALL abort the frame and discard any buffered byte; no Tx_Done is produced for it.

Structure
REQ-028 Package uart_pkg SHALL hold the state encoding and the default DATA_BITS/STOP_BITS/parity constants shared with the future receiver.
REQ-029 No sub-module; the tick detector, holding buffer and FSM are in one module.

Verification (bench Baud_Clk toggles every 4 Clock_In cycles -> 8-cycle bit period)
REQ-030 Send 0xA5, defaults -> Tx_Serial 0,1,0,1,0,0,1,0,1,1, each 8 cycles; one Tx_Done pulse; Tx_Busy low afterwards.
REQ-031 Send 0x00, then 0xFF accepted mid-frame -> 20 contiguous bit periods, start of frame 2 immediately after stop of frame 1, two Tx_Done pulses.
REQ-032 PARITY_EN=1: 0x07 even -> parity bit 1; PARITY_ODD=1 -> parity bit 0.
REQ-033 Reset asserted during data bit 3 of 0x3C with a byte buffered -> Tx_Serial=1 at once, Tx_Ready=1, Tx_Busy=0, no Tx_Done, no later transmission.
REQ-034 Three bytes 0x11,0x22,0x33 offered continuously -> Tx_Ready low while the buffer is full, all three sent in order, none lost.
REQ-035 STOP_BITS=2, send 0x55 -> stop level high for 16 cycles before Tx_Done.
